fp_mul_arbiter: RTL

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier between two requesters.
// Latency: MUL_LATENCY cycles from accept edge to respN_valid; readies are combinational.
// Backpressure: requesters stall on reqN_ready (one accept per cycle); responses cannot be stalled.
module fp_mul_arbiter #(
    parameter int DW          = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          resp0_valid,
    output logic [DW-1:0] resp0_result,
    output logic          resp1_valid,
    output logic [DW-1:0] resp1_result,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    input  logic [DW-1:0] mul_result,
    output logic          busy,
    output logic [15:0]   issue_count
);

    logic                   grant0;
    logic                   grant1;
    logic                   issue;
    logic                   last_grant;
    logic [MUL_LATENCY-1:0] tag_vld;
    logic [MUL_LATENCY-1:0] tag_id;
    logic [15:0]            issue_cnt;

    // last_grant == 1 means req1 won the previous issue, so req0 wins the next tie.
    always_comb begin
        grant0 = rst & req0_valid & (~req1_valid | last_grant);
        grant1 = rst & req1_valid & (~req0_valid | ~last_grant);
        issue  = grant0 | grant1;
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant0) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (grant1) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld    <= '0;
            tag_id     <= '0;
            last_grant <= 1'b1;
            issue_cnt  <= '0;
        end else begin
            tag_vld[0] <= issue;
            tag_id[0]  <= grant1;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            if (issue) begin
                last_grant <= grant1;
                if (issue_cnt != 16'hFFFF) begin
                    issue_cnt <= issue_cnt + 16'd1;
                end
            end
        end
    end

    // The final tag stage lines up with the multiplier output, so the result bus is shared.
    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign resp0_valid  = tag_vld[MUL_LATENCY-1] & ~tag_id[MUL_LATENCY-1];
    assign resp1_valid  = tag_vld[MUL_LATENCY-1] &  tag_id[MUL_LATENCY-1];
    assign resp0_result = mul_result;
    assign resp1_result = mul_result;
    assign busy         = |tag_vld;
    assign issue_count  = issue_cnt;

endmodule
